// File: rtl/fv_fetch_unit.sv
// fv_fetch_unit: per-PE feature-vector fetch engine. Issues one tagged read
// request to the FV bank controller, captures the sos/eos response stream into a
// single-vector buffer and exposes it through a registered read port.
module fv_fetch_unit #(
    parameter int unsigned PE_ID       = 0,
    parameter int unsigned NUM_EDGE_PE = 4,
    parameter int unsigned FV_BW       = 32,
    parameter int unsigned MAX_FV_NUM  = 16,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned TIMEOUT     = 255,
    localparam int unsigned TW  = (NUM_EDGE_PE > 1) ? $clog2(NUM_EDGE_PE) : 1,
    localparam int unsigned D   = MAX_FV_NUM / 2,
    localparam int unsigned PW  = (D > 1) ? $clog2(D) : 1,
    localparam int unsigned NW  = $clog2(MAX_FV_NUM) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NW-1:0]     Num_FV,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    input  logic              bank_busy,
    output logic              fv_req_valid,
    output logic [ADDR_W-1:0] fv_req_addr,
    output logic [TW-1:0]     fv_req_PE_tag,
    input  logic              fv_valid,
    input  logic              fv_sos,
    input  logic              fv_eos,
    input  logic [TW-1:0]     fv_PE_tag,
    input  logic [FV_BW-1:0]  fv_data,
    input  logic [PW-1:0]     rd_addr,
    output logic [FV_BW-1:0]  rd_data,
    output logic              vec_ready,
    input  logic              vec_release,
    output logic              fv_done,
    output logic              fv_err
);

    localparam int unsigned CW  = PW + 1;
    localparam int unsigned TOW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TOW-1:0] TmoLast = TOW'(TIMEOUT - 1);
    localparam logic [NW-1:0]  MaxFv   = NW'(MAX_FV_NUM);
    localparam logic [CW-1:0]  DepthW  = CW'(D);
    localparam logic [CW-1:0]  One     = CW'(1);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StRecv, StHold} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CW-1:0]      exp_q, exp_d;
    logic [TOW-1:0]     tmo_q, tmo_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [FV_BW-1:0]   rd_data_q;
    logic [FV_BW-1:0]   fv_buf_q [D];

    logic               beat_acc;
    logic               wr_en;
    logic [PW-1:0]      wr_idx;
    logic [NW:0]        nf_plus;
    logic [CW-1:0]      exp_calc;

    assign beat_acc      = fv_valid && (fv_PE_tag == TW'(PE_ID));
    assign fv_req_PE_tag = TW'(PE_ID);
    assign fv_req_addr   = addr_q;
    assign rd_data       = rd_data_q;
    assign fv_done       = done_q;
    assign fv_err        = err_q;

    // Expected word count: two features per word, 0 means one word, clamp to buffer depth.
    always_comb begin
        nf_plus = {1'b0, Num_FV} + 1'b1;
        if (Num_FV == '0) begin
            exp_calc = One;
        end else if (Num_FV > MaxFv) begin
            exp_calc = DepthW;
        end else begin
            exp_calc = CW'(nf_plus >> 1);
        end
    end

    // Next-state, capture control and decoded outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        exp_d        = exp_q;
        tmo_d        = tmo_q;
        addr_d       = addr_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        wr_en        = 1'b0;
        wr_idx       = '0;
        req_ready    = (state_q == StIdle);
        vec_ready    = (state_q == StHold);
        fv_req_valid = (state_q == StReq) && !bank_busy;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    exp_d   = exp_calc;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (!bank_busy) begin
                    tmo_d   = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (beat_acc) begin
                    tmo_d = '0;
                    if (fv_sos) begin
                        wr_en = 1'b1;
                        cnt_d = One;
                        if (exp_q == One) begin
                            done_d  = 1'b1;
                            state_d = StHold;
                        end else begin
                            state_d = StRecv;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (tmo_q == TmoLast) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StRecv: begin
                if (beat_acc) begin
                    tmo_d = '0;
                    if (fv_sos) begin
                        // Restarted stream: recapture from word 0 but flag the glitch.
                        wr_en = 1'b1;
                        cnt_d = One;
                        err_d = 1'b1;
                    end else begin
                        wr_en  = 1'b1;
                        wr_idx = cnt_q[PW-1:0];
                        cnt_d  = cnt_q + 1'b1;
                        if (cnt_q == exp_q - One) begin
                            done_d  = 1'b1;
                            state_d = StHold;
                        end else if (fv_eos) begin
                            err_d   = 1'b1;
                            state_d = StIdle;
                        end
                    end
                end else if (tmo_q == TmoLast) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StHold: begin
                if (vec_release) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            exp_q     <= One;
            tmo_q     <= '0;
            addr_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            exp_q     <= exp_d;
            tmo_q     <= tmo_d;
            addr_q    <= addr_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rd_data_q <= fv_buf_q[rd_addr];
        end
    end

    // Vector buffer; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            fv_buf_q[wr_idx] <= fv_data;
        end
    end

endmodule

// File: tb/tb_fv_fetch_unit.sv
// Directed self-checking bench for fv_fetch_unit (PE_ID=1, TIMEOUT=10).
module tb_fv_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  Num_FV;
    logic        req_valid;
    logic [7:0]  req_addr;
    logic        req_ready;
    logic        bank_busy;
    logic        fv_req_valid;
    logic [7:0]  fv_req_addr;
    logic [1:0]  fv_req_PE_tag;
    logic        fv_valid;
    logic        fv_sos;
    logic        fv_eos;
    logic [1:0]  fv_PE_tag;
    logic [31:0] fv_data;
    logic [2:0]  rd_addr;
    logic [31:0] rd_data;
    logic        vec_ready;
    logic        vec_release;
    logic        fv_done;
    logic        fv_err;

    int n_tests = 0;
    int n_fail  = 0;
    int err_seen = 0;

    fv_fetch_unit #(
        .PE_ID      (1),
        .NUM_EDGE_PE(4),
        .FV_BW      (32),
        .MAX_FV_NUM (16),
        .ADDR_W     (8),
        .TIMEOUT    (10)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .Num_FV       (Num_FV),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_ready    (req_ready),
        .bank_busy    (bank_busy),
        .fv_req_valid (fv_req_valid),
        .fv_req_addr  (fv_req_addr),
        .fv_req_PE_tag(fv_req_PE_tag),
        .fv_valid     (fv_valid),
        .fv_sos       (fv_sos),
        .fv_eos       (fv_eos),
        .fv_PE_tag    (fv_PE_tag),
        .fv_data      (fv_data),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .vec_ready    (vec_ready),
        .vec_release  (vec_release),
        .fv_done      (fv_done),
        .fv_err       (fv_err)
    );

    always #5 clk = ~clk;

    // Count every cycle in which fv_err is high.
    always @(negedge clk) begin
        if (fv_err === 1'b1) err_seen++;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic beat(input logic sos, input logic eos, input logic [1:0] tag,
                        input logic [31:0] data);
        fv_valid  = 1'b1;
        fv_sos    = sos;
        fv_eos    = eos;
        fv_PE_tag = tag;
        fv_data   = data;
        step();
        fv_valid  = 1'b0;
        fv_sos    = 1'b0;
        fv_eos    = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, ".fv_req_valid"}, 32'(fv_req_valid), 32'd0);
        chk({tag, ".vec_ready"}, 32'(vec_ready), 32'd0);
        chk({tag, ".fv_done"}, 32'(fv_done), 32'd0);
        chk({tag, ".fv_err"}, 32'(fv_err), 32'd0);
        chk({tag, ".rd_data"}, rd_data, 32'd0);
    endtask

    initial begin
        reset = 1'b1; Num_FV = '0; req_valid = 1'b0; req_addr = '0; bank_busy = 1'b0;
        fv_valid = 1'b0; fv_sos = 1'b0; fv_eos = 1'b0; fv_PE_tag = '0; fv_data = '0;
        rd_addr = '0; vec_release = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        check_reset_vals("rst");

        // Single-word vector.
        Num_FV = 5'd2; req_addr = 8'h12; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        chk("t1.req_valid", 32'(fv_req_valid), 32'd1);
        chk("t1.req_addr", 32'(fv_req_addr), 32'h12);
        chk("t1.req_tag", 32'(fv_req_PE_tag), 32'd1);
        chk("t1.req_ready_busy", 32'(req_ready), 32'd0);
        step();
        chk("t1.req_valid_once", 32'(fv_req_valid), 32'd0);
        rd_addr = 3'd0;
        beat(1'b1, 1'b1, 2'd1, 32'hA5A5A5A5);
        chk("t1.vec_ready", 32'(vec_ready), 32'd1);
        chk("t1.fv_done", 32'(fv_done), 32'd1);
        step();
        chk("t1.rd_data", rd_data, 32'hA5A5A5A5);
        chk("t1.fv_done_pulse", 32'(fv_done), 32'd0);

        // HOLD ignores req_valid; release with req_valid is accepted one cycle later.
        req_valid = 1'b1;
        step();
        chk("hold.req_ready", 32'(req_ready), 32'd0);
        chk("hold.vec_ready", 32'(vec_ready), 32'd1);
        vec_release = 1'b1; Num_FV = 5'd8; req_addr = 8'h34;
        step();
        vec_release = 1'b0;
        chk("rel.req_ready", 32'(req_ready), 32'd1);
        chk("rel.vec_ready", 32'(vec_ready), 32'd0);
        chk("rel.no_req", 32'(fv_req_valid), 32'd0);
        step();
        req_valid = 1'b0;
        chk("rel.req_next", 32'(fv_req_valid), 32'd1);
        chk("rel.req_addr", 32'(fv_req_addr), 32'h34);

        // Multi-word vector with a foreign-tag beat in the middle.
        step();
        beat(1'b1, 1'b1, 2'd1, 32'd1);
        chk("t2.not_ready", 32'(vec_ready), 32'd0);
        beat(1'b1, 1'b0, 2'd0, 32'hDEAD);
        beat(1'b0, 1'b0, 2'd1, 32'd2);
        beat(1'b0, 1'b0, 2'd1, 32'd3);
        chk("t2.not_done", 32'(fv_done), 32'd0);
        beat(1'b0, 1'b1, 2'd1, 32'd4);
        chk("t2.fv_done", 32'(fv_done), 32'd1);
        chk("t2.vec_ready", 32'(vec_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            rd_addr = 3'(i);
            step();
            chk($sformatf("t2.buf%0d", i), rd_data, 32'(i + 1));
        end
        chk("t2.no_err", 32'(err_seen), 32'd0);
        vec_release = 1'b1;
        step();
        vec_release = 1'b0;

        // Busy hold-off, then eos on beat 2 aborts.
        bank_busy = 1'b1; Num_FV = 5'd8; req_addr = 8'h56; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3.held%0d", i), 32'(fv_req_valid), 32'd0);
            step();
        end
        bank_busy = 1'b0;
        #1;
        chk("t3.req_valid", 32'(fv_req_valid), 32'd1);
        step();
        chk("t3.req_once", 32'(fv_req_valid), 32'd0);
        beat(1'b1, 1'b0, 2'd1, 32'h11);
        beat(1'b0, 1'b1, 2'd1, 32'h22);
        chk("t4.eos_err", 32'(fv_err), 32'd1);
        chk("t4.eos_idle", 32'(req_ready), 32'd1);
        chk("t4.eos_vec", 32'(vec_ready), 32'd0);
        step();
        chk("t4.err_pulse", 32'(fv_err), 32'd0);

        // sos on beat 3 restarts capture at buf[0]; Num_FV=7 also gives four words.
        Num_FV = 5'd7; req_addr = 8'h78; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        beat(1'b1, 1'b0, 2'd1, 32'hA1);
        beat(1'b0, 1'b0, 2'd1, 32'hA2);
        beat(1'b1, 1'b0, 2'd1, 32'hB1);
        chk("t5.sos_err", 32'(fv_err), 32'd1);
        chk("t5.still_busy", 32'(req_ready), 32'd0);
        beat(1'b0, 1'b0, 2'd1, 32'hB2);
        beat(1'b0, 1'b0, 2'd1, 32'hB3);
        chk("t5.not_done", 32'(fv_done), 32'd0);
        beat(1'b0, 1'b1, 2'd1, 32'hB4);
        chk("t5.fv_done", 32'(fv_done), 32'd1);
        for (int i = 0; i < 4; i++) begin
            rd_addr = 3'(i);
            step();
            chk($sformatf("t5.buf%0d", i), rd_data, 32'hB1 + 32'(i));
        end
        vec_release = 1'b1;
        step();
        vec_release = 1'b0;

        // Timeout with no response.
        Num_FV = 5'd4; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        repeat (9) step();
        chk("t6.pre_err", 32'(fv_err), 32'd0);
        chk("t6.pre_ready", 32'(req_ready), 32'd0);
        step();
        chk("t6.tmo_err", 32'(fv_err), 32'd1);
        chk("t6.tmo_ready", 32'(req_ready), 32'd1);

        // Reset in the middle of RECV discards the stream.
        Num_FV = 5'd8; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        beat(1'b1, 1'b0, 2'd1, 32'h77);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_vals("mid_rst");
        beat(1'b0, 1'b1, 2'd1, 32'h88);
        chk("mid_rst.ignored", 32'(req_ready), 32'd1);
        chk("err_total", 32'(err_seen), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fv_fetch_unit.md
# fv_fetch_unit

Edge-PE-side counterpart of the FV bank controller. It issues one feature-vector read request (bank address plus own PE tag) to the bank controller and waits for the response. It then captures the tagged sos/eos response stream into a local single-vector buffer and presents the complete vector to the PE datapath through a registered read port. One instance sits in each Edge PE, between the PE scheduler and the shared FV bank response bus.

## Interface

- Reset is synchronous and active-high. There is one clock (`clk`) and reset is `reset`.

Parameters:
- PE_ID, 0: tag this instance accepts on the response bus.
- NUM_EDGE_PE, 4: number of Edge PEs; tag width TW = clog2(NUM_EDGE_PE).
- FV_BW, 32: response word width. Each word carries two features.
- MAX_FV_NUM, 16: maximum features per vector. Buffer depth D = MAX_FV_NUM/2 words. Pointer width PW = clog2(D).
- ADDR_W, 8: bank address width.
- TIMEOUT, 255: idle cycles allowed in WAIT/RECV before abort.

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous active-high reset.
- Num_FV, in, clog2(MAX_FV_NUM)+1: features per vector. Sampled on request acceptance.
- req_valid, in, 1: scheduler fetch request.
- req_addr, in, ADDR_W: bank address of the vector.
- req_ready, out, 1: high in IDLE only.
- bank_busy, in, 1: bank controller Busy.
- fv_req_valid, out, 1: request strobe to the bank controller.
- fv_req_addr, out, ADDR_W: latched address.
- fv_req_PE_tag, out, TW: constant PE_ID.
- fv_valid, in, 1: response beat valid.
- fv_sos, in, 1: start-of-stream.
- fv_eos, in, 1: end-of-stream.
- fv_PE_tag, in, TW: destination tag of the beat.
- fv_data, in, FV_BW: beat payload.
- rd_addr, in, PW: buffer read address.
- rd_data, out, FV_BW: registered read data.
- vec_ready, out, 1: buffer holds a complete vector.
- vec_release, in, 1: consumer frees the buffer.
- fv_done, out, 1: one-cycle pulse when the vector completes.
- fv_err, out, 1: one-cycle pulse on protocol error or timeout.

## Operation

- **Beat acceptance:** a beat is accepted only when fv_valid=1 and fv_PE_tag==PE_ID, and the state is WAIT or RECV. All other beats are ignored with no side effect.
- **Expected word count:** exp = (Num_FV+1)>>1 at request acceptance. Num_FV=0 is treated as exp=1. Num_FV>MAX_FV_NUM saturates to D.
- **Word counter:** cnt, PW+1 bits. Cleared on every sos beat.

States:
- **IDLE:** req_ready=1. On req_valid, latch req_addr and exp, then go to REQ.
- **REQ:** fv_req_valid = !bank_busy (decoded from state). In the cycle it is high, go to WAIT. Otherwise stay in REQ.
- **WAIT:** accepted beat with sos=1: write fv_data to buf[0] and set cnt=1. If exp==1, the vector is done; otherwise go to RECV. An accepted beat with sos=0 pulses fv_err and the FSM stays in WAIT.
- **RECV:** accepted beat with sos=0: write buf[cnt], then cnt++. The beat with cnt==exp-1 completes the vector.
  - An accepted beat with sos=1 restarts the capture: write buf[0], cnt=1, pulse fv_err.
  - An accepted beat with eos=1 and sos=0 while cnt<exp-1: pulse fv_err and go to IDLE.
  - eos on a sos beat is not an end marker. It is ignored whenever exp>1.
- **Vector done:** pulse fv_done and go to HOLD.
- **HOLD:** vec_ready=1 and req_ready=0. vec_release returns the FSM to IDLE. req_valid asserted in the same cycle as vec_release is not accepted; it is accepted in the following IDLE cycle.
- **Timeout:** the timeout counter clears on entry to WAIT and on every accepted beat, and increments each cycle in WAIT/RECV. When it reaches TIMEOUT, pulse fv_err and go to IDLE.
- **Read port:** always active, independent of state.

## Timing

- **Reset values:** state=IDLE, req_ready=1, fv_req_valid=0, vec_ready=0, fv_done=0, fv_err=0, rd_data=0, cnt=0, timeout counter=0. Buffer contents are not reset.
- **Request latency:**
  - req_valid accepted at edge t.
  - fv_req_valid is high in cycle t+1 if bank_busy=0.
  - Otherwise it is held off one cycle at a time until bank_busy=0.
  - fv_req_valid is never high for more than one cycle per request.
- **Buffer writes:** a beat accepted in cycle t is written at edge t.
- **Completion:** after the final beat in cycle t, vec_ready and fv_done are high in cycle t+1. fv_done lasts one cycle.
- **Read latency:** rd_addr presented in cycle t gives rd_data in cycle t+1.
- **Mid-operation reset:** reset asserted mid-operation forces the reset values at the next edge. A stream in flight is discarded.

## Test plan

- **Single-word vector:** Num_FV=2, req_addr=0x12, bank_busy=0. Expect fv_req_valid for exactly 1 cycle with addr 0x12 and tag PE_ID. Drive one beat {sos=1, eos=1, data=0xA5A5A5A5}. Expect vec_ready and fv_done 1 cycle later, and rd_addr=0 to read 0xA5A5A5A5.
- **Multi-word vector with foreign beat:** Num_FV=8 (exp=4). Drive 4 tagged beats of data 1,2,3,4, with the first beat carrying sos=eos=1, plus a foreign-tag beat in between. Expect buf=1,2,3,4, fv_done after beat 4, and fv_err never asserted.
- **Busy hold-off:** bank_busy high for 5 cycles after acceptance. Expect fv_req_valid=0 during those 5 cycles, then high for exactly 1 cycle.
- **Protocol errors:** with exp=4, an eos on beat 2 pulses fv_err, returns the FSM to IDLE, and keeps vec_ready=0. Separately, a sos on beat 3 pulses fv_err and restarts capture at buf[0].
- **Timeout:** TIMEOUT=10 with no response. Expect fv_err 10 cycles after entering WAIT, then req_ready=1.
- **HOLD behaviour and reset:**
  - In HOLD, req_valid is ignored.
  - vec_release together with req_valid: the request is accepted 1 cycle later.
  - reset asserted mid-RECV: all outputs take their reset values next cycle.
